// File: rtl/div_q_pkg.sv
// Shared types and constants for the fixed-point divider slice.
// The saturating result path in div_q_core is enabled by defining DIV_SATURATE_EN.
package div_q_pkg;

  localparam int Q_BITS_DEFAULT = 10;
  localparam int W              = 32 + Q_BITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } state_t;

  localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] QMIN = 32'h8000_0000;

  // Widened to 33 bits so that -2^31 yields +2^31 instead of wrapping.
  function automatic logic [32:0] abs33(input logic [31:0] v);
    return v[31] ? (33'd0 - {v[31], v}) : {1'b0, v};
  endfunction

endpackage

// File: rtl/div_q_core.sv
// Restoring divider FSM (IDLE/CALC/WRITE), one quotient bit per cycle.
// Define DIV_SATURATE_EN to clamp overflow and divide-by-zero to QMAX/QMIN.
module div_q_core
  import div_q_pkg::*;
#(
  parameter int Q_BITS = Q_BITS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] num,
  input  logic        num_empty,
  output logic        num_rd_en,
  input  logic [31:0] den,
  input  logic        den_empty,
  output logic        den_rd_en,
  output logic [31:0] out,
  input  logic        out_full,
  output logic        out_wr_en
);

  localparam int DW = 32 + Q_BITS;
  localparam int CW = $clog2(DW + 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   dividend_q;
  logic [32:0]     divisor_q;
  logic [32:0]     rem_q;
  logic [DW-1:0]   quot_q;
  logic            sign_q;
  logic [31:0]     result_q;

  logic            pop;
  logic [32:0]     num_abs;
  logic [32:0]     den_abs;
  logic [33:0]     rem_shift;
  logic            rem_ge;
  logic [32:0]     rem_d;
  logic [DW-1:0]   quot_d;
  logic [31:0]     result_d;

  always_comb begin
    pop       = (state_q == IDLE) && !num_empty && !den_empty;
    num_abs   = abs33(num);
    den_abs   = abs33(den);
    rem_shift = {rem_q, dividend_q[DW-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    rem_d     = rem_ge ? 33'(rem_shift - {1'b0, divisor_q}) : rem_shift[32:0];
    quot_d    = {quot_q[DW-2:0], rem_ge};
`ifdef DIV_SATURATE_EN
    if (divisor_q == '0) begin
      result_d = sign_q ? QMIN : QMAX;
    end else if (!sign_q && (quot_d > DW'(QMAX))) begin
      result_d = QMAX;
    end else if (sign_q && (quot_d > DW'(QMIN))) begin
      result_d = QMIN;
    end else begin
      result_d = 32'(sign_q ? (DW'(0) - quot_d) : quot_d);
    end
`else
    result_d = 32'(sign_q ? (DW'(0) - quot_d) : quot_d);
`endif
  end

  assign num_rd_en = pop;
  assign den_rd_en = pop;
  assign out       = result_q;
  assign out_wr_en = (state_q == WRITE) && !out_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      sign_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            dividend_q <= DW'(num_abs) << Q_BITS;
            divisor_q  <= den_abs;
            sign_q     <= num[31] ^ den[31];
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          rem_q      <= rem_d;
          quot_q     <= quot_d;
          dividend_q <= dividend_q << 1;
          if (cnt_q == CW'(DW - 1)) begin
            result_q <= result_d;
            state_q  <= WRITE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          // Result register stays put while the output FIFO is full.
          if (!out_full) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo.sv
// Single-clock show-ahead FIFO; dout presents the head word and reads zero when empty.
// Depth in words is FIFO_BUFFER_SIZE / FIFO_DATA_WIDTH.
module fifo #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 512
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] din,
  output logic                       full,
  input  logic                       rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] dout,
  output logic                       empty
);

  localparam int DEPTH = FIFO_BUFFER_SIZE / FIFO_DATA_WIDTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]              wr_ptr_q;
  logic [AW-1:0]              rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       do_wr;
  logic                       do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (do_wr && !do_rd) begin
        count_q <= count_q + 1'b1;
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_q.sv
// Divider stage top: pops num/den pairs in lock-step and queues quotients in an output FIFO.
// Saturating behaviour is selected at build time with DIV_SATURATE_EN.
module div_q
  import div_q_pkg::*;
#(
  parameter int Q_BITS     = Q_BITS_DEFAULT,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] num,
  input  logic        num_empty,
  output logic        num_rd_en,
  input  logic [31:0] den,
  input  logic        den_empty,
  output logic        den_rd_en,
  output logic [31:0] out,
  output logic        out_empty,
  input  logic        out_rd_en
);

  logic [31:0] core_out;
  logic        out_full;
  logic        out_wr_en;

  div_q_core #(
    .Q_BITS(Q_BITS)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .num      (num),
    .num_empty(num_empty),
    .num_rd_en(num_rd_en),
    .den      (den),
    .den_empty(den_empty),
    .den_rd_en(den_rd_en),
    .out      (core_out),
    .out_full (out_full),
    .out_wr_en(out_wr_en)
  );

  fifo #(
    .FIFO_DATA_WIDTH (32),
    .FIFO_BUFFER_SIZE(32 * FIFO_DEPTH)
  ) u_out_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(out_wr_en),
    .din  (core_out),
    .full (out_full),
    .rd_en(out_rd_en),
    .dout (out),
    .empty(out_empty)
  );

endmodule

// File: tb/tb_div_q.sv
// Scoreboard bench for div_q: stimulus pushes hand-computed quotients, a monitor pops and compares.
// Expected values follow DIV_SATURATE_EN when it is defined for the build.
module tb_div_q;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] num = '0;
  logic        num_empty = 1'b1;
  logic        num_rd_en;
  logic [31:0] den = '0;
  logic        den_empty = 1'b1;
  logic        den_rd_en;
  logic [31:0] out;
  logic        out_empty;
  logic        out_rd_en = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int num_pops = 0;
  int den_pops = 0;
  int lone_pops = 0;
  int received = 0;
  int pop_cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  bit drain_en = 1'b1;
  bit pulse_req = 1'b0;

  logic [31:0] vec_num [10];
  logic [31:0] vec_den [10];
  logic [31:0] vec_exp [10];

  div_q dut (
    .clock    (clock),
    .reset    (reset),
    .num      (num),
    .num_empty(num_empty),
    .num_rd_en(num_rd_en),
    .den      (den),
    .den_empty(den_empty),
    .den_rd_en(den_rd_en),
    .out      (out),
    .out_empty(out_empty),
    .out_rd_en(out_rd_en)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (num_rd_en) num_pops <= num_pops + 1;
    if (den_rd_en) den_pops <= den_pops + 1;
    if (num_rd_en != den_rd_en) lone_pops <= lone_pops + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: consumes the output FIFO head whenever draining is allowed.
  initial begin
    forever begin
      @(negedge clock);
      out_rd_en = 1'b0;
      if (!reset && !out_empty && (drain_en || pulse_req)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", out, mon_exp);
        end
        $display("txn out   out=%h", out);
        out_rd_en = 1'b1;
        pulse_req = 1'b0;
        received++;
      end
    end
  end

  task automatic issue(input logic [31:0] n, input logic [31:0] d, input bit push, input logic [31:0] e);
    int t;
    t = 0;
    @(negedge clock);
    num = n;
    den = d;
    num_empty = 1'b0;
    den_empty = 1'b0;
    #1;
    while (!(num_rd_en && den_rd_en) && t < 300) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got no pop expected pop for num=%h den=%h", n, d);
    end else begin
      pop_cyc = cyc;
      if (push) exp_q.push_back(e);
      $display("txn issue num=%h den=%h expect=%h", n, d, push ? e : 32'h0);
    end
    @(posedge clock);
    #1;
    num_empty = 1'b1;
    den_empty = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int t;
    int p0;
    int d0;
    int r0;

    vec_num = '{32'hFFFFF400, 32'hFFFFF400, 32'd1, 32'd7168, 32'hFFFFFFFF,
                32'd1024, 32'hFFFFFC00, 32'h40000000, 32'h80000000, 32'd0};
    vec_den = '{32'd2048, 32'hFFFFF800, 32'd3072, 32'd2048, 32'd3072,
                32'd0, 32'd0, 32'd1, 32'd1024, 32'd0};
`ifdef DIV_SATURATE_EN
    vec_exp = '{32'hFFFFFA00, 32'd1536, 32'd0, 32'd3584, 32'd0,
                32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
`else
    vec_exp = '{32'hFFFFFA00, 32'd1536, 32'd0, 32'd3584, 32'd0,
                32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
`endif

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_out_empty_held", {31'b0, out_empty}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("reset_out_empty", {31'b0, out_empty}, 32'd1);
    check("reset_out", out, 32'd0);
    check("reset_num_rd_en", {31'b0, num_rd_en}, 32'd0);
    check("reset_den_rd_en", {31'b0, den_rd_en}, 32'd0);

    // Basic divide with latency and single lock-step pop
    p0 = num_pops;
    d0 = den_pops;
    issue(32'd3072, 32'd2048, 1'b1, 32'd1536);
    t = 0;
    while (out_empty && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("latency_to_not_empty", 32'(cyc - pop_cyc), 32'd44);
    check("basic_num_pops", 32'(num_pops - p0), 32'd1);
    check("basic_den_pops", 32'(den_pops - d0), 32'd1);

    // Signs, truncation, divide by zero, overflow, -2^31 boundary
    for (int i = 0; i < 10; i++) begin
      issue(vec_num[i], vec_den[i], 1'b1, vec_exp[i]);
    end
    wait_drain("drain_vectors");

    // One side empty: never pop
    @(negedge clock);
    num = 32'd5;
    den = 32'd7;
    num_empty = 1'b0;
    den_empty = 1'b1;
    p0 = num_pops;
    d0 = den_pops;
    repeat (20) @(negedge clock);
    check("num_only_no_num_pop", 32'(num_pops - p0), 32'd0);
    check("num_only_no_den_pop", 32'(den_pops - d0), 32'd0);
    num_empty = 1'b1;
    den_empty = 1'b0;
    repeat (20) @(negedge clock);
    check("den_only_no_pop", 32'(num_pops + den_pops - p0 - d0), 32'd0);
    den_empty = 1'b1;

    // Back-pressure: fill output FIFO, then one extra result stuck in WRITE
    drain_en = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      issue(32'(k * 1024), 32'd1024, 1'b1, 32'(k * 1024));
    end
    @(negedge clock);
    num = 32'(18 * 1024);
    den = 32'd1024;
    num_empty = 1'b0;
    den_empty = 1'b0;
    p0 = num_pops;
    repeat (100) @(negedge clock);
    check("hold_write_no_pop", 32'(num_pops - p0), 32'd0);
    check("full_not_empty", {31'b0, out_empty}, 32'd0);
    r0 = received;
    pulse_req = 1'b1;
    issue(32'(18 * 1024), 32'd1024, 1'b1, 32'(18 * 1024));
    check("single_pulse_reads", 32'(received - r0), 32'd1);
    drain_en = 1'b1;
    wait_drain("drain_backpressure");

    // Reset mid-CALC discards the in-flight result
    issue(32'd5120, 32'd1024, 1'b0, 32'd0);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midcalc_reset_empty", {31'b0, out_empty}, 32'd1);
    reset = 1'b0;
    r0 = received;
    repeat (60) @(negedge clock);
    check("midcalc_no_write", {31'b0, out_empty}, 32'd1);
    check("midcalc_no_output", 32'(received - r0), 32'd0);
    issue(32'd3072, 32'd1024, 1'b1, 32'd3072);
    wait_drain("drain_after_reset");

    check("lone_pops", 32'(lone_pops), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
